// File: rtl/mac_ctrl.sv
// mac_ctrl: streaming fixed-point dot-product engine.
// Operand pairs are multiplied, accumulated, then saturated to WIDTH.
module mac_ctrl #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LEN_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int PW    = 2*WIDTH-FRAC_WIDTH;
  localparam int ACC_W = PW+LEN_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0]         count;
  logic signed [PW-1:0]     p_reg;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic [ACC_W-WIDTH:0]     hi;
  logic                     fits;
  logic [WIDTH-1:0]         sat_val;
  logic                     xfer_in;

  assign a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
  assign b_ext = {{WIDTH{in_b[WIDTH-1]}}, in_b};
  assign prod  = a_ext * b_ext;

  // p_reg is zeroed on idle cycles so each product lands in acc exactly once
  assign sum  = acc + {{LEN_W{p_reg[PW-1]}}, p_reg};
  assign hi   = sum[ACC_W-1:WIDTH-1];
  assign fits = (&hi) | ~(|hi);

  always_comb begin
    sat_val = sum[WIDTH-1:0];
    if (!fits) begin
      if (hi[ACC_W-WIDTH])
        sat_val = {1'b1, {(WIDTH-1){1'b0}}};
      else
        sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign xfer_in   = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len != '0) ? ACCUM : OUT;
      end
      ACCUM: begin
        if (xfer_in && count == LEN_W'(1))
          state_nx = DRAIN;
      end
      DRAIN: state_nx = OUT;
      OUT: begin
        if (out_ready)
          state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      p_reg    <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            count <= len;
            acc   <= '0;
            p_reg <= '0;
            if (len == '0) begin
              out_data <= '0;
              out_ovf  <= 1'b0;
            end
          end
        end
        ACCUM: begin
          acc <= sum;
          if (xfer_in) begin
            p_reg <= PW'(prod >>> FRAC_WIDTH);
            count <= count - 1'b1;
          end else begin
            p_reg <= '0;
          end
        end
        DRAIN: begin
          out_data <= sat_val;
          out_ovf  <= ~fits;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: directed self-checking bench for mac_ctrl.
// Expected results are hand-computed Q8.8 dot products.
module tb_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int total  = 0;
  int passed = 0;

  logic [15:0] va[4];
  logic [15:0] vb[4];
  int          ga[4];

  mac_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_job(input int n, input bit spur, output int lat);
    int w;
    start = 1'b1;
    len   = n[6:0];
    tick;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (ga[i]) begin
        start = spur;
        len   = 7'd5;
        tick;
      end
      start    = 1'b0;
      in_a     = va[i];
      in_b     = vb[i];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
        tick;
        w++;
      end
      total++;
      if (!in_ready)
        $display("FAIL in_ready_timeout: in_ready=%b want 1", in_ready);
      else
        passed++;
      tick;
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    start     = 1'b1;
    len       = 7'd3;
    in_valid  = 1'b1;
    in_a      = 16'h1234;
    in_b      = 16'h5678;
    out_ready = 1'b0;
    tick;
    tick;
    total++;
    if ({busy, out_valid, in_ready, out_ovf} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000",
               {busy, out_valid, in_ready, out_ovf});
    else passed++;
    total++;
    if (out_data !== 16'h0000)
      $display("FAIL reset_data: got %h want 0000", out_data);
    else passed++;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0)
      $display("FAIL reset_idle: busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b1;
    va[0] = 16'h0180; vb[0] = 16'h0200; ga[0] = 0;
    va[1] = 16'hFF00; vb[1] = 16'h0080; ga[1] = 0;
    feed_job(2, 1'b0, lat);
    total++;
    if (lat !== 1)
      $display("FAIL basic_latency: got %0d want 1", lat);
    else passed++;
    total++;
    if (out_data !== 16'h0280)
      $display("FAIL basic_data: got %h want 0280", out_data);
    else passed++;
    total++;
    if (out_ovf !== 1'b0)
      $display("FAIL basic_ovf: got %b want 0", out_ovf);
    else passed++;
    tick;
    total++;
    if ({out_valid, busy} !== 2'b00)
      $display("FAIL basic_done: got %b want 00", {out_valid, busy});
    else passed++;
  endtask

  task automatic test_saturation;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      va[i] = 16'h7F00; vb[i] = 16'h7F00; ga[i] = 0;
    end
    feed_job(4, 1'b0, lat);
    total++;
    if ({out_data, out_ovf} !== {16'h7FFF, 1'b1})
      $display("FAIL sat_pos: got %h/%b want 7fff/1", out_data, out_ovf);
    else passed++;
    tick;
    for (int i = 0; i < 4; i++) vb[i] = 16'h8100;
    feed_job(4, 1'b0, lat);
    total++;
    if ({out_data, out_ovf} !== {16'h8000, 1'b1})
      $display("FAIL sat_neg: got %h/%b want 8000/1", out_data, out_ovf);
    else passed++;
    tick;
  endtask

  task automatic test_rounding;
    int lat;
    out_ready = 1'b1;
    va[0] = 16'h0001; vb[0] = 16'h0080; ga[0] = 0;
    feed_job(1, 1'b0, lat);
    total++;
    if ({out_data, out_ovf} !== {16'h0000, 1'b0})
      $display("FAIL round_pos: got %h/%b want 0000/0", out_data, out_ovf);
    else passed++;
    tick;
    va[0] = 16'hFFFF;
    feed_job(1, 1'b0, lat);
    total++;
    if ({out_data, out_ovf} !== {16'hFFFF, 1'b0})
      $display("FAIL round_neg: got %h/%b want ffff/0", out_data, out_ovf);
    else passed++;
    tick;
  endtask

  task automatic test_flow;
    int lat;
    bit stable;
    out_ready = 1'b0;
    va[0] = 16'h0100; vb[0] = 16'h0300; ga[0] = 2;
    va[1] = 16'h0200; vb[1] = 16'hFF00; ga[1] = 0;
    va[2] = 16'h0080; vb[2] = 16'h0080; ga[2] = 3;
    feed_job(3, 1'b1, lat);
    total++;
    if (lat !== 1)
      $display("FAIL flow_latency: got %0d want 1", lat);
    else passed++;
    total++;
    if ({out_data, out_ovf} !== {16'h0140, 1'b0})
      $display("FAIL flow_data: got %h/%b want 0140/0", out_data, out_ovf);
    else passed++;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 7'd2;
      tick;
      if (!out_valid || out_data !== 16'h0140 || out_ovf !== 1'b0)
        stable = 1'b0;
    end
    total++;
    if (!stable)
      $display("FAIL flow_stall: got %b/%h want 1/0140", out_valid, out_data);
    else passed++;
    out_ready = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if ({out_valid, busy} !== 2'b00)
      $display("FAIL flow_release: got %b want 00", {out_valid, busy});
    else passed++;
  endtask

  task automatic test_len0;
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 7'd0;
    tick;
    start = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b110)
      $display("FAIL len0_flags: got %b want 110",
               {out_valid, busy, in_ready});
    else passed++;
    total++;
    if ({out_data, out_ovf} !== {16'h0000, 1'b0})
      $display("FAIL len0_data: got %h/%b want 0000/0", out_data, out_ovf);
    else passed++;
    out_ready = 1'b1;
    tick;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL len0_done: out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int lat;
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 7'd3;
    tick;
    start    = 1'b0;
    in_a     = 16'h0400;
    in_b     = 16'h0400;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    rst      = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({busy, out_valid, in_ready} !== 3'b000)
      $display("FAIL abort_flags: got %b want 000",
               {busy, out_valid, in_ready});
    else passed++;
    tick;
    tick;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL abort_no_out: out_valid=%b want 0", out_valid);
    else passed++;
    va[0] = 16'h0100; vb[0] = 16'h0100; ga[0] = 0;
    feed_job(1, 1'b0, lat);
    total++;
    if ({out_valid, out_data, out_ovf} !== {1'b1, 16'h0100, 1'b0})
      $display("FAIL abort_next: got %b/%h/%b want 1/0100/0",
               out_valid, out_data, out_ovf);
    else passed++;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_rounding;
    test_flow;
    test_len0;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
